// File: rtl/if_id_decode.sv
// IF/ID pipeline register with field decode, sign_extend control and
// load-use hazard detection against the EX stage.
module if_id_decode #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr_in,
    input  logic [31:0]            pc_plus4_in,
    input  logic                   if_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rt,
    output logic                   id_valid,
    output logic [31:0]            instr_q,
    output logic [31:0]            pc_plus4_q,
    output logic [5:0]             opcode,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             shamt,
    output logic [5:0]             funct,
    output logic [15:0]            imm16,
    output logic                   ext_ctrl,
    output logic [25:0]            target26,
    output logic                   hazard_stall,
    output logic                   if_hold,
    output logic                   id_bubble,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   id_valid_q, id_valid_d;
    logic [31:0]            instr_d, pc_plus4_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic                   uses_rs, uses_rt;

    assign id_valid     = id_valid_q;
    assign stall_cycles = stall_cycles_q;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign shamt    = instr_q[10:6];
    assign funct    = instr_q[5:0];
    assign imm16    = instr_q[15:0];
    assign target26 = instr_q[25:0];

    always_comb begin
        // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
        ext_ctrl = id_valid_q && (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E);
        uses_rs  = !(opcode == 6'h02 || opcode == 6'h03 || opcode == 6'h0F);
        uses_rt  = (opcode == 6'h00 || opcode == 6'h04 || opcode == 6'h05 || opcode == 6'h2B);
        hazard_stall = id_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
                       ((uses_rs && ex_rt == rs) || (uses_rt && ex_rt == rt));
        if_hold   = stall || hazard_stall;
        id_bubble = hazard_stall || !id_valid_q;
    end

    always_comb begin
        id_valid_d     = id_valid_q;
        instr_d        = instr_q;
        pc_plus4_d     = pc_plus4_q;
        stall_cycles_d = stall_cycles_q;
        if (if_hold && stall_cycles_q != {STALL_CNT_W{1'b1}})
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (flush) begin
            id_valid_d = 1'b0;
            instr_d    = 32'd0;
            pc_plus4_d = 32'd0;
        end else if (!if_hold) begin
            id_valid_d = if_valid;
            instr_d    = if_valid ? instr_in : 32'd0;
            pc_plus4_d = pc_plus4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q     <= 1'b0;
            instr_q        <= 32'd0;
            pc_plus4_q     <= 32'd0;
            stall_cycles_q <= '0;
        end else begin
            id_valid_q     <= id_valid_d;
            instr_q        <= instr_d;
            pc_plus4_q     <= pc_plus4_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_if_id_decode.sv
// Randomized and directed bench for if_id_decode against a behavioural model.
module tb_if_id_decode;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          reset, if_valid, stall, flush, ex_mem_read;
    logic [31:0]   instr_in, pc_plus4_in;
    logic [4:0]    ex_rt;
    logic          id_valid, ext_ctrl, hazard_stall, if_hold, id_bubble;
    logic [31:0]   instr_q, pc_plus4_q;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm16;
    logic [25:0]   target26;
    logic [W-1:0]  stall_cycles;

    int checks = 0;
    int failures = 0;

    // Model state
    bit          m_valid;
    bit [31:0]   m_instr, m_pc;
    int          m_cnt;

    if_id_decode #(.STALL_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
        .if_valid(if_valid), .stall(stall), .flush(flush), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .id_valid(id_valid), .instr_q(instr_q), .pc_plus4_q(pc_plus4_q),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .ext_ctrl(ext_ctrl), .target26(target26),
        .hazard_stall(hazard_stall), .if_hold(if_hold), .id_bubble(id_bubble),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        int op, s, t;
        bit urs, urt;
        op  = m_instr / (1 << 26);
        s   = (m_instr / (1 << 21)) % 32;
        t   = (m_instr / (1 << 16)) % 32;
        urs = !(op == 2 || op == 3 || op == 15);
        urt = (op == 0 || op == 4 || op == 5 || op == 43);
        return m_valid && ex_mem_read && ex_rt != 0 &&
               ((urs && ex_rt == s) || (urt && ex_rt == t));
    endfunction

    // Check all outputs against the model, then advance one clock edge.
    task automatic step();
        bit hz, hold;
        int op;
        #2;
        hz   = m_hazard();
        hold = stall || hz;
        op   = m_instr / (1 << 26);
        chk("id_valid", id_valid, m_valid);
        chk("instr_q", instr_q, m_instr);
        chk("pc_plus4_q", pc_plus4_q, m_pc);
        chk("opcode", opcode, op);
        chk("rs", rs, (m_instr / (1 << 21)) % 32);
        chk("rt", rt, (m_instr / (1 << 16)) % 32);
        chk("rd", rd, (m_instr / (1 << 11)) % 32);
        chk("shamt", shamt, (m_instr / (1 << 6)) % 32);
        chk("funct", funct, m_instr % 64);
        chk("imm16", imm16, m_instr % 65536);
        chk("target26", target26, m_instr % (1 << 26));
        chk("ext_ctrl", ext_ctrl, m_valid && (op == 12 || op == 13 || op == 14));
        chk("hazard_stall", hazard_stall, hz);
        chk("if_hold", if_hold, hold);
        chk("id_bubble", id_bubble, hz || !m_valid);
        chk("stall_cycles", stall_cycles, m_cnt);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_cnt = 0;
        end else begin
            if (hold && m_cnt < (1 << W) - 1) m_cnt++;
            if (flush) begin
                m_valid = 0; m_instr = 0; m_pc = 0;
            end else if (!hold) begin
                m_valid = if_valid;
                m_instr = if_valid ? instr_in : 32'd0;
                m_pc    = pc_plus4_in;
            end
        end
        #1;
    endtask

    task automatic drive(input bit r, input bit [31:0] ins, input bit [31:0] pc, input bit v,
                         input bit st, input bit fl, input bit mr, input bit [4:0] ert);
        reset = r; instr_in = ins; pc_plus4_in = pc; if_valid = v;
        stall = st; flush = fl; ex_mem_read = mr; ex_rt = ert;
    endtask

    function automatic bit [31:0] rand_instr();
        bit [5:0] ops [12];
        bit [31:0] r;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h2B};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 11)];
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_valid = 0; m_instr = 0; m_pc = 0; m_cnt = 0;
        step();                                           // second reset cycle
        // Reset and load addi $9,$8,-4
        drive(0, 32'h2109FFFC, 32'h10, 1, 0, 0, 0, 0); step();
        chk("addi_opcode", opcode, 6'h08);
        chk("addi_imm", imm16, 16'hFFFC);
        // ori -> zero-extend, addiu -> sign-extend
        drive(0, 32'h3509ABCD, 32'h14, 1, 0, 0, 0, 0); step();
        chk("ori_ext", ext_ctrl, 1'b1);
        drive(0, 32'h2509ABCD, 32'h18, 1, 0, 0, 0, 0); step();
        chk("addiu_ext", ext_ctrl, 1'b0);
        // Load-use hazard against add $10,$9,$11
        drive(0, 32'h012B5020, 32'h1C, 1, 0, 0, 0, 0); step();
        drive(0, 32'hDEADBEEF, 32'h20, 1, 0, 0, 1, 9);  step();
        chk("hold_instr", instr_q, 32'h012B5020);
        chk("hold_cnt", stall_cycles, 1);
        drive(0, 32'hDEADBEEF, 32'h20, 1, 0, 0, 1, 11); step();
        drive(0, 32'hDEADBEEF, 32'h20, 1, 0, 0, 1, 0);  #2; chk("ex_rt0_nohz", hazard_stall, 0); #1;
        ex_rt = 12; #2; chk("ex_rt12_nohz", hazard_stall, 0); #1;
        drive(0, 32'hDEADBEEF, 32'h20, 1, 0, 0, 1, 12); step();
        // Flush over stall with hazard present
        drive(0, 32'h012B5020, 32'h24, 1, 0, 0, 0, 0); step();
        drive(0, 32'h11111111, 32'h28, 1, 1, 1, 1, 9); step();
        chk("flush_instr", instr_q, 0);
        chk("flush_bubble", id_bubble, 1);
        // Bubble, then 3-cycle hold
        drive(0, 32'h22222222, 32'h2C, 0, 0, 0, 0, 0); step();
        drive(0, 32'h3509ABCD, 32'h30, 1, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h33333333, 32'h40, 1, 1, 0, 0, 0); step();
        end
        chk("hold3_instr", instr_q, 32'h3509ABCD);
        // Saturation, then reset mid-stall
        for (int i = 0; i < 20; i++) begin
            drive(0, 32'h44444444, 32'h44, 1, 1, 0, 0, 0); step();
        end
        chk("sat_cnt", stall_cycles, 4'hF);
        drive(1, 32'h44444444, 32'h44, 1, 1, 0, 0, 0); step();
        chk("rst_cnt", stall_cycles, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, rand_instr(), $urandom, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
